// File: rtl/hex_line_decoder.sv
// ASCII hex line decoder: accumulates up to DIGITS hex characters per CR/LF-terminated line
// and presents the value on a valid/ready output. Define HEX_LINE_DECODER_LOWERCASE_EN to accept "a"-"f".
module hex_line_decoder #(
    parameter int DIGITS = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [7:0]            rx_data,
    input  logic                  rx_valid,
    output logic                  rx_ready,
    output logic [4*DIGITS-1:0]   value_data,
    output logic [3:0]            value_len,
    output logic                  value_valid,
    input  logic                  value_ready,
    output logic                  err
);

    typedef enum logic [1:0] {
        IDLE,
        ACCUM,
        OUT,
        SKIP
    } state_t;

    localparam logic [3:0] MAX_CNT = 4'(DIGITS);

    state_t                r_state;
    logic [4*DIGITS-1:0]   r_acc;
    logic [3:0]            r_cnt;
    logic                  r_err;

    logic                  w_accept;
    logic                  w_is_hex;
    logic                  w_is_term;
    logic [3:0]            w_nibble;
    logic [4*DIGITS-1:0]   w_nib_ext;

    assign w_accept  = rx_valid && rx_ready;
    assign w_nib_ext = (4*DIGITS)'(w_nibble);

    // NOTE: every variable gets a default before the if-chain so no latch is inferred.
    always_comb begin
        w_is_hex  = 1'b0;
        w_nibble  = 4'h0;
        w_is_term = (rx_data == 8'h0D) || (rx_data == 8'h0A);
        if (rx_data >= 8'h30 && rx_data <= 8'h39) begin
            w_is_hex = 1'b1;
            w_nibble = rx_data[3:0];
        end else if (rx_data >= 8'h41 && rx_data <= 8'h46) begin
            w_is_hex = 1'b1;
            w_nibble = rx_data[3:0] + 4'd9;
        end
`ifdef HEX_LINE_DECODER_LOWERCASE_EN
        else if (rx_data >= 8'h61 && rx_data <= 8'h66) begin
            w_is_hex = 1'b1;
            w_nibble = rx_data[3:0] + 4'd9;
        end
`endif
    end

    // NOTE: state is updated with non-blocking assignments so every branch sees pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
            r_acc   <= '0;
            r_cnt   <= '0;
            r_err   <= 1'b0;
        end else begin
            r_err <= 1'b0;
            unique case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        if (w_is_hex) begin
                            r_acc   <= w_nib_ext;
                            r_cnt   <= 4'd1;
                            r_state <= ACCUM;
                        end else if (!w_is_term) begin
                            r_err   <= 1'b1;
                            r_state <= SKIP;
                        end
                    end
                end
                ACCUM: begin
                    if (w_accept) begin
                        if (w_is_hex) begin
                            if (r_cnt == MAX_CNT) begin
                                r_err   <= 1'b1;
                                r_state <= SKIP;
                            end else begin
                                r_acc <= (r_acc << 4) | w_nib_ext;
                                r_cnt <= r_cnt + 4'd1;
                            end
                        end else if (w_is_term) begin
                            r_state <= OUT;
                        end else begin
                            r_err   <= 1'b1;
                            r_state <= SKIP;
                        end
                    end
                end
                OUT: begin
                    if (value_ready) begin
                        r_acc   <= '0;
                        r_cnt   <= '0;
                        r_state <= IDLE;
                    end
                end
                SKIP: begin
                    if (w_accept && w_is_term) begin
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // Input is stalled only while a value is outstanding, so no byte is ever dropped.
    assign rx_ready    = (r_state != OUT);
    assign value_valid = (r_state == OUT);
    assign value_data  = r_acc;
    assign value_len   = r_cnt;
    assign err         = r_err;

endmodule

// File: tb/tb_hex_line_decoder.sv
// Self-checking bench for hex_line_decoder (DIGITS=4): directed lines, scoreboard of expected values,
// error-pulse and handshake checks. Expectations follow HEX_LINE_DECODER_LOWERCASE_EN when defined.
module tb_hex_line_decoder;

    typedef struct packed {
        logic [15:0] data;
        logic [3:0]  len;
    } exp_t;

    logic        clk;
    logic        reset;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic [15:0] value_data;
    logic [3:0]  value_len;
    logic        value_valid;
    logic        value_ready;
    logic        err;

    int   tests   = 0;
    int   fails   = 0;
    int   err_cnt = 0;
    int   xfers   = 0;
    exp_t sb[$];

    hex_line_decoder #(.DIGITS(4)) dut (
        .clk         (clk),
        .reset       (reset),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .rx_ready    (rx_ready),
        .value_data  (value_data),
        .value_len   (value_len),
        .value_valid (value_valid),
        .value_ready (value_ready),
        .err         (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Output side of the scoreboard: every value handshake pops one expected entry.
    always @(negedge clk) begin
        if (!reset && value_valid && value_ready) begin
            exp_t e;
            xfers++;
            check("sb_has_entry", 32'(sb.size() != 0), 32'd1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                check("value_data", 32'(value_data), 32'(e.data));
                check("value_len", 32'(value_len), 32'(e.len));
            end
        end
    end

    always @(negedge clk) begin
        if (!reset && err) err_cnt++;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic send_byte(input logic [7:0] b);
        int waited = 0;
        rx_data  = b;
        rx_valid = 1'b1;
        @(negedge clk);
        while (!rx_ready && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        check("rx_ready_wait", 32'(rx_ready), 32'd1);
        @(posedge clk);
        #1;
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) send_byte(s[i]);
    endtask

    task automatic idle(input int n);
        rx_valid = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [15:0] d, input logic [3:0] l);
        exp_t e;
        e.data = d;
        e.len  = l;
        sb.push_back(e);
    endtask

    initial begin
        int e0;
        int x0;
        reset       = 1'b1;
        rx_valid    = 1'b0;
        rx_data     = 8'h00;
        value_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_rx_ready", 32'(rx_ready), 32'd1);
        check("rst_value_valid", 32'(value_valid), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_value_len", 32'(value_len), 32'd0);
        check("rst_value_data", 32'(value_data), 32'd0);
        reset = 1'b0;
        @(posedge clk);
        #1;

        // "1A3F\r" back-to-back
        e0 = err_cnt;
        x0 = xfers;
        send_str("1A3F");
        push(16'h1A3F, 4'd4);
        send_byte(8'h0D);
        check("lat_value_valid", 32'(value_valid), 32'd1);
        check("lat_rx_ready", 32'(rx_ready), 32'd0);
        check("lat_value_data", 32'(value_data), 32'h1A3F);
        idle(3);
        check("t1_err_none", 32'(err_cnt), 32'(e0));
        check("t1_xfers", 32'(xfers), 32'(x0 + 1));

        // "\n\n7\n": empty lines are silent
        e0 = err_cnt;
        x0 = xfers;
        send_byte(8'h0A);
        send_byte(8'h0A);
        check("empty_no_valid", 32'(value_valid), 32'd0);
        send_byte("7");
        push(16'h0007, 4'd1);
        send_byte(8'h0A);
        idle(3);
        check("t2_err_none", 32'(err_cnt), 32'(e0));
        check("t2_xfers", 32'(xfers), 32'(x0 + 1));

        // "12345\r00FF\n": overflow on the fifth digit
        e0 = err_cnt;
        x0 = xfers;
        send_str("1234");
        send_byte("5");
        check("ovf_err_pulse", 32'(err), 32'd1);
        send_byte(8'h0D);
        check("ovf_err_one_cycle", 32'(err), 32'd0);
        send_str("00FF");
        push(16'h00FF, 4'd4);
        send_byte(8'h0A);
        idle(3);
        check("t3_err_count", 32'(err_cnt), 32'(e0 + 1));
        check("t3_xfers", 32'(xfers), 32'(x0 + 1));

        // "1g\rab\r": illegal byte, then lowercase digits
        e0 = err_cnt;
        x0 = xfers;
        send_byte("1");
        send_byte("g");
        check("illegal_err_pulse", 32'(err), 32'd1);
        send_byte(8'h0D);
        check("skip_term_no_err", 32'(err), 32'd0);
        send_byte("a");
`ifdef HEX_LINE_DECODER_LOWERCASE_EN
        check("lower_a_no_err", 32'(err), 32'd0);
        send_byte("b");
        push(16'h00AB, 4'd2);
        send_byte(8'h0D);
        idle(3);
        check("t4_err_count", 32'(err_cnt), 32'(e0 + 1));
        check("t4_xfers", 32'(xfers), 32'(x0 + 1));
`else
        check("lower_a_err", 32'(err), 32'd1);
        send_byte("b");
        send_byte(8'h0D);
        idle(3);
        check("t4_err_count", 32'(err_cnt), 32'(e0 + 2));
        check("t4_xfers", 32'(xfers), 32'(x0));
`endif

        // "BEEF\r" with the consumer stalled for 10 cycles
        value_ready = 1'b0;
        x0 = xfers;
        send_str("BEEF");
        push(16'hBEEF, 4'd4);
        send_byte(8'h0D);
        rx_valid = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("stall_rx_ready", 32'(rx_ready), 32'd0);
            check("stall_value_valid", 32'(value_valid), 32'd1);
            check("stall_value_data", 32'(value_data), 32'hBEEF);
            check("stall_value_len", 32'(value_len), 32'd4);
        end
        @(posedge clk);
        #1;
        value_ready = 1'b1;
        @(posedge clk);
        #1;
        check("post_xfer_rx_ready", 32'(rx_ready), 32'd1);
        check("post_xfer_valid", 32'(value_valid), 32'd0);
        idle(3);
        check("t5_xfers", 32'(xfers), 32'(x0 + 1));

        // "12", reset pulse, then "3\r"
        x0 = xfers;
        send_str("12");
        rx_valid = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("mid_rst_rx_ready", 32'(rx_ready), 32'd1);
        check("mid_rst_valid", 32'(value_valid), 32'd0);
        check("mid_rst_len", 32'(value_len), 32'd0);
        check("mid_rst_data", 32'(value_data), 32'd0);
        reset = 1'b0;
        @(posedge clk);
        #1;
        send_byte("3");
        push(16'h0003, 4'd1);
        send_byte(8'h0D);
        idle(3);
        check("t6_xfers", 32'(xfers), 32'(x0 + 1));

        check("sb_drained", 32'(sb.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/hex_line_decoder.md
HEX_LINE_DECODER -- requirements
Module: hex_line_decoder

Interface
REQ-001 The block SHALL have a parameter DIGITS, default 4, giving the maximum hex digits per line, legal range 1..8.
REQ-002 clk  in  1  the single clock for all logic; the 50 MHz domain.
REQ-003 reset  in  1  asynchronous, active-high reset.
REQ-004 rx_data  in  8  ASCII byte from the UART receiver.
REQ-005 rx_valid  in  1  rx_data holds a byte this cycle.
REQ-006 rx_ready  out  1  the block accepts the byte this cycle; a transfer is rx_valid && rx_ready.
REQ-007 value_data  out  4*DIGITS  the decoded value, right-aligned and zero-extended.
REQ-008 value_len  out  4  the number of digits in value_data, 1..DIGITS.
REQ-009 value_valid  out  1  value_data and value_len are presented to the consumer.
REQ-010 value_ready  in  1  the consumer accepts the value; a transfer is value_valid && value_ready.
REQ-011 err  out  1  one-cycle pulse when a line is rejected.

Function
REQ-012 Each ASCII hex character SHALL decode to its nibble: "0"-"9" decode to 0-9, and "A"-"F" decode to 10-15.
REQ-013 A terminator SHALL be CR (0x0D) or LF (0x0A); every other non-hex byte is illegal.
REQ-014 The FSM SHALL have exactly the states IDLE, ACCUM, OUT and SKIP.
REQ-015 In IDLE, a terminator SHALL be discarded, because an empty line produces no output and no error.
REQ-016 In IDLE, a hex byte SHALL load acc={0,nibble} and cnt=1, and move the FSM to ACCUM.
REQ-017 In IDLE, an illegal byte SHALL move the FSM to SKIP.
REQ-018 In ACCUM, a hex byte with cnt<DIGITS SHALL set acc=(acc<<4)|nibble and cnt=cnt+1.
REQ-019 In ACCUM, a hex byte with cnt==DIGITS is an overflow and SHALL move the FSM to SKIP.
REQ-020 In ACCUM, a terminator SHALL move the FSM to OUT.
REQ-021 In ACCUM, an illegal byte SHALL move the FSM to SKIP.
REQ-022 Every entry to SKIP SHALL assert err for exactly the one cycle after the offending byte is accepted.
REQ-023 In SKIP, accepted bytes SHALL be discarded until a terminator is accepted, which returns the FSM to IDLE with no further err.
REQ-024 In OUT, value_valid SHALL be 1, value_data SHALL equal acc, and value_len SHALL equal cnt.
REQ-025 In OUT, a value transfer SHALL clear acc and cnt and return the FSM to IDLE.
REQ-026 rx_ready SHALL be 0 in OUT and 1 in every other state, so at most one value is outstanding and no input byte is ever dropped.
REQ-027 value_data and value_len SHALL stay stable while value_valid=1 and value_ready=0.
REQ-028 Latency: a terminator accepted at edge N SHALL make value_valid=1 after edge N+1.
REQ-029 After a value transfer at edge M, rx_ready SHALL be 1 after edge M+1.
REQ-030 value_valid SHALL be 0 whenever the FSM is not in OUT.
REQ-031 One byte SHALL be processed per cycle, back-to-back, with no bubbles outside OUT.

Reset
REQ-032 Reset SHALL force the FSM to IDLE with acc=0, cnt=0, value_valid=0, err=0 and rx_ready=1, regardless of any line or output in progress.
REQ-033 After reset deasserts, the block SHALL treat the next accepted byte as the start of a new line.

Configuration
REQ-034 The macro HEX_LINE_DECODER_LOWERCASE_EN SHALL control lowercase input.
REQ-035 With HEX_LINE_DECODER_LOWERCASE_EN defined, "a"-"f" SHALL decode to 10-15 exactly as "A"-"F" do.
REQ-036 Without HEX_LINE_DECODER_LOWERCASE_EN defined, "a"-"f" SHALL be illegal bytes.

Verification (DIGITS=4)
REQ-037 Input "1A3F\r" back-to-back SHALL produce value_data=16'h1A3F and value_len=4 after one cycle, with err never asserted.
REQ-038 Input "\n\n7\n" SHALL produce exactly one value, value_data=16'h0007 with value_len=1.
REQ-039 Input "12345\r00FF\n" SHALL assert err once, one cycle after the "5" is accepted, and produce exactly one value, 16'h00FF with value_len=4.
REQ-040 Input "1g\rab\r" SHALL assert err for "g" in both builds.
REQ-041 For the "ab\r" part of that input, the build with the macro SHALL produce 16'h00AB with value_len=2, and the build without it SHALL assert a second err and produce no value.
REQ-042 Input "BEEF\r" with value_ready held low for 10 cycles SHALL keep rx_ready=0 and value_data=16'hBEEF stable.
REQ-043 When value_ready then rises, the block SHALL complete exactly one value transfer and return rx_ready to 1 one cycle later.
REQ-044 Input "12" followed by a reset pulse and then "3\r" SHALL produce value_data=16'h0003 with value_len=1.
